// File: rtl/fp_mult_execute_pipe.sv
// FP multiply execute stage: full mantissa product, biased exponent sum and sign
// through a LAT-deep elastic pipeline. Optional zero flag via FPMULT_EXEC_ZERO_EN.
module fp_mult_execute_pipe #(
  parameter int unsigned MW   = 24,
  parameter int unsigned EW   = 8,
  parameter int unsigned BIAS = 127,
  parameter int unsigned LAT  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [MW-1:0]              Ma,
  input  logic [MW-1:0]              Mb,
  input  logic [EW-1:0]              Ea,
  input  logic [EW-1:0]              Eb,
  input  logic                       Sa,
  input  logic                       Sb,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*MW-1:0]            Mp,
  output logic [EW+1:0]              Ep,
  output logic                       Sp,
`ifdef FPMULT_EXEC_ZERO_EN
  output logic                       zero,
`endif
  output logic [$clog2(LAT+1)-1:0]   inflight
);

  localparam int unsigned PW = 2 * MW;
  localparam int unsigned XW = EW + 2;
  localparam int unsigned CW = $clog2(LAT + 1);

  typedef struct packed {
    logic [PW-1:0] mp;
    logic [XW-1:0] ep;
    logic          sp;
`ifdef FPMULT_EXEC_ZERO_EN
    logic          zero;
`endif
  } stage_t;

  stage_t           in_stage;
  stage_t           data     [LAT];
  stage_t           src_data [LAT];
  logic [LAT-1:0]   valid;
  logic [LAT-1:0]   src_valid;
  logic [LAT-1:0]   load;
  logic             accept;
  logic             out_fire;

  // Arithmetic is done once at entry; later stages only carry the result.
  always_comb begin
    in_stage    = '0;
    in_stage.mp = PW'(Ma) * PW'(Mb);
    in_stage.ep = XW'(Ea) + XW'(Eb) - XW'(BIAS);
    in_stage.sp = Sa ^ Sb;
`ifdef FPMULT_EXEC_ZERO_EN
    in_stage.zero = (Ma == '0) || (Mb == '0);
    if (in_stage.zero) begin
      in_stage.ep = '0;
    end
`endif
  end

  // A stage loads if it, or any stage downstream of it, is empty, or the output drains.
  for (genvar k = 0; k < LAT; k++) begin : g_load
    assign load[k] = out_ready | ~(&valid[LAT-1:k]);
  end

  if (LAT == 1) begin : g_src_one
    assign src_valid = in_valid;
  end else begin : g_src_many
    assign src_valid = {valid[LAT-2:0], in_valid};
  end

  for (genvar k = 0; k < LAT; k++) begin : g_src_data
    if (k == 0) begin : g_head
      assign src_data[k] = in_stage;
    end else begin : g_body
      assign src_data[k] = data[k-1];
    end
  end

  assign in_ready  = load[0];
  assign out_valid = valid[LAT-1];
  assign accept    = in_valid & load[0] & ~flush;
  assign out_fire  = valid[LAT-1] & out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= '0;
    end else begin
      valid <= (load & src_valid) | (~load & valid);
    end
  end

  // Only the output stage is reset; inner data is qualified by its valid bit.
  for (genvar k = 0; k < LAT; k++) begin : g_data
    if (k == LAT - 1) begin : g_out
      always_ff @(posedge clk) begin
        if (rst) begin
          data[k] <= '0;
        end else if (load[k] && src_valid[k]) begin
          data[k] <= src_data[k];
        end
      end
    end else begin : g_mid
      always_ff @(posedge clk) begin
        if (load[k] && src_valid[k]) begin
          data[k] <= src_data[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      inflight <= '0;
    end else if (accept && !out_fire) begin
      inflight <= inflight + CW'(1);
    end else if (!accept && out_fire) begin
      inflight <= inflight - CW'(1);
    end
  end

  assign Mp = data[LAT-1].mp;
  assign Ep = data[LAT-1].ep;
  assign Sp = data[LAT-1].sp;
`ifdef FPMULT_EXEC_ZERO_EN
  assign zero = data[LAT-1].zero;
`endif

endmodule

// File: tb/tb_fp_mult_execute_pipe.sv
// Scoreboard bench for fp_mult_execute_pipe: driver pushes model results, monitor pops and compares.
module tb_fp_mult_execute_pipe;

  localparam int unsigned MW  = 24;
  localparam int unsigned EW  = 8;
  localparam int unsigned LAT = 3;
  localparam int unsigned PW  = 48;
  localparam int unsigned XW  = 10;
  localparam int unsigned CW  = 2;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [MW-1:0] Ma, Mb;
  logic [EW-1:0] Ea, Eb;
  logic          Sa, Sb, Sp;
  logic [PW-1:0] Mp;
  logic [XW-1:0] Ep;
  logic [CW-1:0] inflight;
  logic          zero;

  typedef struct {
    logic [PW-1:0] mp;
    logic [XW-1:0] ep;
    logic          sp;
    logic          zero;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   peak  = 0;
  bit   mon_en = 1'b0;
  bit   saw_block;
  bit   last_acc;

  fp_mult_execute_pipe #(.MW(MW), .EW(EW), .BIAS(127), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .Ma(Ma), .Mb(Mb), .Ea(Ea), .Eb(Eb), .Sa(Sa), .Sb(Sb),
    .out_valid(out_valid), .out_ready(out_ready),
    .Mp(Mp), .Ep(Ep), .Sp(Sp),
`ifdef FPMULT_EXEC_ZERO_EN
    .zero(zero),
`endif
    .inflight(inflight)
  );

`ifndef FPMULT_EXEC_ZERO_EN
  assign zero = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [MW-1:0] a, b, input logic [EW-1:0] ea, eb,
                                 input logic sa, sb);
    exp_t   e;
    longint p;
    int     x;
    p = longint'(a) * longint'(b);
    x = int'(ea) + int'(eb) - 127;
    e.mp = p[PW-1:0];
    e.ep = x[XW-1:0];
    e.sp = sa ^ sb;
    e.zero = 1'b0;
`ifdef FPMULT_EXEC_ZERO_EN
    if (a == 0 || b == 0) begin
      e.zero = 1'b1;
      e.mp   = '0;
      e.ep   = '0;
    end
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc(input logic v, input logic [MW-1:0] a, b, input logic [EW-1:0] ea, eb,
                     input logic sa, sb, input logic ordy, fl, rs);
    @(negedge clk);
    in_valid = v; Ma = a; Mb = b; Ea = ea; Eb = eb; Sa = sa; Sb = sb;
    flush = fl; rst = rs;
    out_ready = ordy & ~fl & ~rs;
    #1;
    last_acc = v && in_ready && !fl && !rs;
    if (v && !in_ready) saw_block = 1'b1;
    @(posedge clk);
    if (rs || fl) q.delete();
    else if (last_acc) q.push_back(model(a, b, ea, eb, sa, sb));
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, ordy, 1'b0, 1'b0);
  endtask

  task automatic rnd_beat(input logic ordy);
    logic [MW-1:0] a, b;
    a = ($urandom_range(0, 9) == 0) ? '0 : MW'($urandom);
    b = ($urandom_range(0, 9) == 0) ? '0 : MW'($urandom);
    cyc(1'b1, a, b, EW'($urandom), EW'($urandom), 1'($urandom), 1'($urandom), ordy, 1'b0, 1'b0);
  endtask

  // Monitor: occupancy against scoreboard depth, then in-order result check.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!mon_en) continue;
      chk("inflight", 64'(inflight), 64'(q.size()));
      if (int'(inflight) > peak) peak = int'(inflight);
      if (out_valid) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_out: out_valid=1 with no expected result at %0t", $time);
        end else if (out_ready) begin
          e = q.pop_front();
          chk("Mp", 64'(Mp), 64'(e.mp));
          chk("Ep", 64'(Ep), 64'(e.ep));
          chk("Sp", 64'(Sp), 64'(e.sp));
          chk("zero", 64'(zero), 64'(e.zero));
        end
      end
    end
  end

  initial begin
    int n;
    int sent;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    Ma = '0; Mb = '0; Ea = '0; Eb = '0; Sa = 1'b0; Sb = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_Mp", 64'(Mp), 64'd0);
    chk("rst_Ep", 64'(Ep), 64'd0);
    chk("rst_Sp", 64'(Sp), 64'd0);
    chk("rst_inflight", 64'(inflight), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    mon_en = 1'b1;

    // 1.0 * -1.0 and accept-to-valid latency
    cyc(1'b1, 24'h800000, 24'h800000, 8'd127, 8'd127, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (n = 1; n <= 10; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #3;
      if (out_valid) break;
      @(posedge clk);
    end
    chk("latency", 64'(n), 64'(LAT));

    cyc(1'b1, 24'hC00000, 24'hC00000, 8'd128, 8'd127, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 24'h800000, 24'h800000, 8'd1, 8'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 24'hFFFFFF, 24'hFFFFFF, 8'd254, 8'd254, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 24'h000000, 24'hC00000, 8'd200, 8'd200, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (5) idle(1'b1);

    // Backpressure: 10 back-to-back beats, output stalled 5 cycles mid-stream
    peak = 0; saw_block = 1'b0; sent = 0;
    for (int c = 0; c < 60 && sent < 10; c++) begin
      rnd_beat(!(c >= 2 && c < 7));
      if (last_acc) sent++;
    end
    repeat (8) idle(1'b1);
    chk("bp_sent", 64'(sent), 64'd10);
    chk("bp_peak", 64'(peak), 64'(LAT));
    chk("bp_in_ready_dropped", 64'(saw_block), 64'd1);

    // Flush with two beats in flight; the beat offered alongside flush is dropped
    rnd_beat(1'b0);
    rnd_beat(1'b0);
    cyc(1'b1, 24'h800000, 24'h800000, 8'd127, 8'd127, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_inflight", 64'(inflight), 64'd0);
    repeat (5) idle(1'b1);

    // Reset mid-stream
    rnd_beat(1'b0);
    rnd_beat(1'b0);
    cyc(1'b1, 24'h800000, 24'h800000, 8'd127, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("rstmid_out_valid", 64'(out_valid), 64'd0);
    chk("rstmid_inflight", 64'(inflight), 64'd0);
    repeat (5) idle(1'b1);

    // Random traffic with random backpressure and occasional flush
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 49) == 0)
        cyc(1'($urandom), MW'($urandom), MW'($urandom), EW'($urandom), EW'($urandom),
            1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      else if ($urandom_range(0, 3) != 0)
        rnd_beat($urandom_range(0, 3) != 0);
      else
        idle($urandom_range(0, 3) != 0);
    end

    for (int c = 0; c < 30 && q.size() != 0; c++) idle(1'b1);
    idle(1'b1);
    chk("drain", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
